// File: rtl/vend_pkg.sv
// Shared definitions for the vending front end and its controller.
//   act_state_e : actuator sequencer states (2-bit)
//   EV_*        : bit positions of the fifty/dollar/cancel lines in event vectors
//   INIT/FIFTY/VEND/RETURN : controller FSM state codes, shared with the controller
package vend_pkg;

   typedef enum logic [1:0] {
      ACT_IDLE = 2'd0,
      ACT_RET  = 2'd1,
      ACT_VND  = 2'd2,
      ACT_GAP  = 2'd3
   } act_state_e;

   localparam int EV_FIFTY  = 0;
   localparam int EV_DOLLAR = 1;
   localparam int EV_CANCEL = 2;
   localparam int EV_NUM    = 3;

   localparam logic [1:0] INIT   = 2'd0;
   localparam logic [1:0] FIFTY  = 2'd1;
   localparam logic [1:0] VEND   = 2'd2;
   localparam logic [1:0] RETURN = 2'd3;

endpackage

// File: rtl/coin_mech_if_if.sv
// Signal bundle between the coin mechanism front end and its surroundings
// (coin/cancel sensors, controller FSM, solenoid drivers).
//   slave  : the coin mechanism (coin_mech_if)
//   master : sensors + controller side (or a testbench)
//
// Signalling: there is no valid/ready back-pressure anywhere on this bus.
// fifty/dollar/cancel are single-cycle event strobes; the controller must
// consume them in the cycle they are high. moneyReturn/dispense are level
// requests whose rising edge is the request; holding them high does not
// repeat it. Solenoid outputs are level drives. act_state and levels are
// debug observation points only.
interface coin_mech_if_if;
   logic       coin50_raw;
   logic       coin100_raw;
   logic       cancel_raw;
   logic       insertCoin;
   logic       moneyReturn;
   logic       dispense;
   logic       fifty;
   logic       dollar;
   logic       cancel;
   logic       reject_gate;
   logic       return_sol;
   logic       vend_sol;
   logic       busy;
   logic [1:0] act_state;
   logic [2:0] levels;

   modport slave (
      input  coin50_raw, coin100_raw, cancel_raw,
      input  insertCoin, moneyReturn, dispense,
      output fifty, dollar, cancel,
      output reject_gate, return_sol, vend_sol, busy,
      output act_state, levels
   );

   modport master (
      output coin50_raw, coin100_raw, cancel_raw,
      output insertCoin, moneyReturn, dispense,
      input  fifty, dollar, cancel,
      input  reject_gate, return_sol, vend_sol, busy,
      input  act_state, levels
   );
endinterface

// File: rtl/coin_mech_if_debounce.sv
// Synchroniser + debouncer for one asynchronous sensor line.
//   clk, rst : clock, synchronous active-high reset
//   raw      : asynchronous sensor input
//   level    : debounced level (registered)
//   rise     : one-cycle strobe in the cycle the debounced level goes 0->1
module coin_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          flip;

   // The counter holds the number of mismatching cycles already seen, so the
   // level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
   assign flip = (sync2 != level) && (cnt == CNT_LAST);
   // Combinational so the owner can arbitrate on it in the flip cycle.
   assign rise = flip & sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (flip) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/coin_mech_if.sv
// Coin mechanism front end for the vending controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : coin_mech_if_if.slave
//     in : coin50_raw, coin100_raw, cancel_raw (async sensors),
//          insertCoin, moneyReturn, dispense (from controller FSM)
//     out: fifty, dollar, cancel (one-cycle events), reject_gate,
//          return_sol, vend_sol (solenoids), busy, act_state/levels (debug)
// Sensor lines are debounced, held one-deep as pending events and issued
// one per cycle (cancel > dollar > fifty). Coins that cannot be accepted
// pulse the reject gate. Return/vend requests run a solenoid sequencer.
module coin_mech_if
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int SOLENOID_CYCLES = 8
) (
   input logic          clk,
   input logic          rst,
   coin_mech_if_if.slave bus
);

   localparam int SW = $clog2(SOLENOID_CYCLES + 1);
   localparam logic [SW-1:0] SOL_LOAD = SW'(SOLENOID_CYCLES);
   localparam logic [SW-1:0] SOL_ONE  = SW'(1);

   localparam logic [1:0] S_IDLE = ACT_IDLE;
   localparam logic [1:0] S_RET  = ACT_RET;
   localparam logic [1:0] S_VND  = ACT_VND;
   localparam logic [1:0] S_GAP  = ACT_GAP;

   // ---------------- input path ----------------
   logic [EV_NUM-1:0] raw_vec;
   logic [EV_NUM-1:0] level_vec;
   logic [EV_NUM-1:0] rise_vec;

   assign raw_vec[EV_FIFTY]  = bus.coin50_raw;
   assign raw_vec[EV_DOLLAR] = bus.coin100_raw;
   assign raw_vec[EV_CANCEL] = bus.cancel_raw;
   assign bus.levels         = level_vec;

   for (genvar i = 0; i < EV_NUM; i++) begin : g_db
      coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_vec[i]),
         .level (level_vec[i]),
         .rise  (rise_vec[i])
      );
   end

   // ---------------- event arbitration ----------------
   logic [EV_NUM-1:0] pend;
   logic [EV_NUM-1:0] cand;
   logic [EV_NUM-1:0] win;
   logic              coin_ok;
   logic              reject_now;
   logic [SW-1:0]     rej_cnt;

   // A rise on an already-pending line merges into the existing flag.
   assign cand    = pend | rise_vec;
   assign coin_ok = bus.insertCoin & ~bus.busy;

   always_comb begin
      win = '0;
      if (cand[EV_CANCEL])      win[EV_CANCEL] = 1'b1;
      else if (cand[EV_DOLLAR]) win[EV_DOLLAR] = 1'b1;
      else if (cand[EV_FIFTY])  win[EV_FIFTY]  = 1'b1;
      reject_now = (win[EV_DOLLAR] | win[EV_FIFTY]) & ~coin_ok;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend            <= '0;
         bus.fifty       <= 1'b0;
         bus.dollar      <= 1'b0;
         bus.cancel      <= 1'b0;
         bus.reject_gate <= 1'b0;
         rej_cnt         <= '0;
      end else begin
         pend       <= cand & ~win;
         bus.cancel <= win[EV_CANCEL];
         bus.dollar <= win[EV_DOLLAR] & coin_ok;
         bus.fifty  <= win[EV_FIFTY] & coin_ok;
         // The gate goes high in the reject cycle and stays high while the
         // remaining count is above one, giving SOLENOID_CYCLES high cycles.
         // A new reject reloads the count, stretching the pulse.
         if (reject_now) begin
            rej_cnt         <= SOL_LOAD;
            bus.reject_gate <= 1'b1;
         end else begin
            if (rej_cnt != '0) rej_cnt <= rej_cnt - SOL_ONE;
            bus.reject_gate <= (rej_cnt > SOL_ONE);
         end
      end
   end

   // ---------------- actuator sequencer ----------------
   logic [1:0]    state;
   logic [1:0]    state_n;
   logic [SW-1:0] sol_cnt;
   logic [SW-1:0] cnt_n;
   logic          ret_req;
   logic          vnd_req;
   logic          ret_n;
   logic          vnd_n;
   logic          mr_q;
   logic          dp_q;
   logic          mr_rise;
   logic          dp_rise;

   assign mr_rise       = bus.moneyReturn & ~mr_q;
   assign dp_rise       = bus.dispense & ~dp_q;
   assign bus.act_state = state;

   always_comb begin
      state_n = state;
      cnt_n   = sol_cnt;
      // A request edge during its own active phase is absorbed.
      ret_n   = ret_req | (mr_rise & (state != S_RET));
      vnd_n   = vnd_req | (dp_rise & (state != S_VND));
      case (state)
         // GAP makes the same choice IDLE would, so queued work follows after
         // exactly one dead cycle instead of an extra pass through IDLE.
         S_IDLE, S_GAP: begin
            if (ret_req) begin
               state_n = S_RET;
               cnt_n   = SOL_LOAD;
               ret_n   = 1'b0;
            end else if (vnd_req) begin
               state_n = S_VND;
               cnt_n   = SOL_LOAD;
               vnd_n   = 1'b0;
            end else begin
               state_n = S_IDLE;
            end
         end
         S_RET, S_VND: begin
            if (sol_cnt == SOL_ONE) begin
               state_n = S_GAP;
               cnt_n   = '0;
            end else begin
               cnt_n = sol_cnt - SOL_ONE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         sol_cnt        <= '0;
         ret_req        <= 1'b0;
         vnd_req        <= 1'b0;
         mr_q           <= 1'b0;
         dp_q           <= 1'b0;
         bus.return_sol <= 1'b0;
         bus.vend_sol   <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         state          <= state_n;
         sol_cnt        <= cnt_n;
         ret_req        <= ret_n;
         vnd_req        <= vnd_n;
         mr_q           <= bus.moneyReturn;
         dp_q           <= bus.dispense;
         bus.return_sol <= (state_n == S_RET);
         bus.vend_sol   <= (state_n == S_VND);
         bus.busy       <= (state_n != S_IDLE);
      end
   end

endmodule

// File: tb/tb_coin_mech_if.sv
// Testbench for coin_mech_if: reset, table-driven single-press vectors,
// hand-written multi-cycle sequences and a randomized press stream checked
// against an event-order model.
module tb_coin_mech_if;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   coin_mech_if_if bus ();

   coin_mech_if #(.DEBOUNCE_CYCLES(4), .SOLENOID_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;

   // event codes: 0 fifty, 1 dollar, 2 cancel, 3 reject pulse start
   logic [1:0] exp_q[$];
   logic [1:0] got_q[$];

   int   c_fifty, c_dollar, c_cancel, c_rej_hi, c_ret_hi, c_vnd_hi, c_busy_hi;
   int   t_fifty, t_dollar, t_cancel;
   int   t_ret_first, t_ret_last, t_vnd_first, t_vnd_last, t_busy_first, t_busy_last;
   logic rej_prev = 1'b0;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      n_checks++;
      if (got < lo || got > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   task automatic clear_mon();
      c_fifty = 0; c_dollar = 0; c_cancel = 0; c_rej_hi = 0;
      c_ret_hi = 0; c_vnd_hi = 0; c_busy_hi = 0;
      t_fifty = -1; t_dollar = -1; t_cancel = -1;
      t_ret_first = -1; t_ret_last = -1; t_vnd_first = -1; t_vnd_last = -1;
      t_busy_first = -1; t_busy_last = -1;
      got_q.delete();
   endtask

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      check_range("event_count", int'(bus.fifty) + int'(bus.dollar) + int'(bus.cancel), 0, 1);
      check("sol_exclusive", int'(bus.return_sol & bus.vend_sol), 0);
      if (bus.fifty)  begin c_fifty++;  t_fifty  = cyc; got_q.push_back(2'd0); end
      if (bus.dollar) begin c_dollar++; t_dollar = cyc; got_q.push_back(2'd1); end
      if (bus.cancel) begin c_cancel++; t_cancel = cyc; got_q.push_back(2'd2); end
      if (bus.reject_gate) begin
         c_rej_hi++;
         if (!rej_prev) got_q.push_back(2'd3);
      end
      rej_prev = bus.reject_gate;
      if (bus.return_sol) begin
         c_ret_hi++;
         if (t_ret_first < 0) t_ret_first = cyc;
         t_ret_last = cyc;
      end
      if (bus.vend_sol) begin
         c_vnd_hi++;
         if (t_vnd_first < 0) t_vnd_first = cyc;
         t_vnd_last = cyc;
      end
      if (bus.busy) begin
         c_busy_hi++;
         if (t_busy_first < 0) t_busy_first = cyc;
         t_busy_last = cyc;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_line(input int line, input logic v);
      case (line)
         0:       bus.coin50_raw  = v;
         1:       bus.coin100_raw = v;
         default: bus.cancel_raw  = v;
      endcase
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_fifty"},  int'(bus.fifty), 0);
      check({tag, "_dollar"}, int'(bus.dollar), 0);
      check({tag, "_cancel"}, int'(bus.cancel), 0);
      check({tag, "_reject"}, int'(bus.reject_gate), 0);
      check({tag, "_ret"},    int'(bus.return_sol), 0);
      check({tag, "_vnd"},    int'(bus.vend_sol), 0);
      check({tag, "_busy"},   int'(bus.busy), 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      int   line;
      logic ins;
      int   hold;
      int   e_fifty;
      int   e_dollar;
      int   e_cancel;
      int   e_rej;
   } vec_t;

   vec_t vt[8];

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   t0;
      int   hs;
      bit   seen;
      int   line;
      logic ins;
      int   hold;
      int   gap;

      vt[0] = '{0, 1'b1, 8,  1, 0, 0, 0};
      vt[1] = '{1, 1'b1, 8,  0, 1, 0, 0};
      vt[2] = '{2, 1'b1, 8,  0, 0, 1, 0};
      vt[3] = '{2, 1'b0, 8,  0, 0, 1, 0};
      vt[4] = '{1, 1'b0, 8,  0, 0, 0, 8};
      vt[5] = '{0, 1'b1, 2,  0, 0, 0, 0};
      vt[6] = '{1, 1'b1, 2,  0, 0, 0, 0};
      vt[7] = '{0, 1'b0, 40, 0, 0, 0, 8};

      bus.coin50_raw  = 1'b0;
      bus.coin100_raw = 1'b0;
      bus.cancel_raw  = 1'b0;
      bus.insertCoin  = 1'b0;
      bus.moneyReturn = 1'b0;
      bus.dispense    = 1'b0;
      clear_mon();

      // ---- reset ----
      rst = 1'b1;
      tick(3);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      tick(2);

      // ---- 1: single 50c coin, latency ----
      clear_mon();
      bus.insertCoin = 1'b1;
      t0 = cyc;
      bus.coin50_raw = 1'b1;
      tick(20);
      bus.coin50_raw = 1'b0;
      tick(15);
      check("t1_fifty_count", c_fifty, 1);
      check_range("t1_latency", t_fifty - t0, 5, 7);
      check("t1_reject_cycles", c_rej_hi, 0);

      // ---- 2: glitchy dollar ----
      clear_mon();
      bus.coin100_raw = 1'b1; tick(1);
      bus.coin100_raw = 1'b0; tick(1);
      hs = cyc;
      bus.coin100_raw = 1'b1; tick(15);
      bus.coin100_raw = 1'b0; tick(15);
      check("t2_dollar_count", c_dollar, 1);
      check("t2_other_events", c_fifty + c_cancel, 0);
      check_range("t2_after_hold", t_dollar - hs, 4, 7);

      // ---- 3: cancel and dollar together ----
      clear_mon();
      bus.cancel_raw  = 1'b1;
      bus.coin100_raw = 1'b1;
      tick(10);
      bus.cancel_raw  = 1'b0;
      bus.coin100_raw = 1'b0;
      tick(15);
      check("t3_cancel_count", c_cancel, 1);
      check("t3_dollar_count", c_dollar, 1);
      check("t3_order", t_dollar - t_cancel, 1);

      // ---- 4: coin rejected when insertCoin=0 ----
      clear_mon();
      bus.insertCoin = 1'b0;
      bus.coin50_raw = 1'b1;
      tick(8);
      bus.coin50_raw = 1'b0;
      tick(25);
      check("t4_fifty_count", c_fifty, 0);
      check("t4_reject_cycles", c_rej_hi, 8);
      check("t4_reject_pulses", got_q.size(), 1);

      // ---- reject restart: second reject 4 cycles into the first ----
      clear_mon();
      bus.coin50_raw = 1'b1;
      tick(4);
      bus.coin100_raw = 1'b1;
      tick(6);
      bus.coin50_raw = 1'b0;
      tick(4);
      bus.coin100_raw = 1'b0;
      tick(25);
      check("rr_reject_cycles", c_rej_hi, 12);
      check("rr_reject_pulses", got_q.size(), 1);

      // ---- coin while actuator busy is rejected ----
      clear_mon();
      bus.insertCoin  = 1'b1;
      bus.moneyReturn = 1'b1;
      tick(2);
      bus.moneyReturn = 1'b0;
      bus.coin50_raw  = 1'b1;
      tick(8);
      bus.coin50_raw  = 1'b0;
      tick(25);
      check("bz_fifty_count", c_fifty, 0);
      check("bz_reject_cycles", c_rej_hi, 8);
      check("bz_ret_cycles", c_ret_hi, 8);

      // ---- 5: return and vend requested together ----
      clear_mon();
      bus.moneyReturn = 1'b1;
      bus.dispense    = 1'b1;
      tick(2);
      bus.moneyReturn = 1'b0;
      bus.dispense    = 1'b0;
      tick(30);
      check("t5_ret_cycles", c_ret_hi, 8);
      check("t5_vnd_cycles", c_vnd_hi, 8);
      check("t5_ret_first", int'(t_ret_first >= 0), 1);
      check("t5_idle_gap", t_vnd_first - t_ret_last, 2);
      check("t5_busy_start", t_busy_first, t_ret_first);
      check("t5_busy_contig", c_busy_hi, t_busy_last - t_busy_first + 1);
      check_range("t5_busy_end", t_busy_last - t_vnd_last, 0, 1);
      check("t5_busy_final", int'(bus.busy), 0);

      // ---- 6: reset in the third return_sol cycle ----
      clear_mon();
      bus.moneyReturn = 1'b1;
      bus.dispense    = 1'b1;
      tick(2);
      bus.moneyReturn = 1'b0;
      bus.dispense    = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         if (bus.return_sol) seen = 1'b1;
      end
      check("t6_ret_seen", int'(seen), 1);
      if (seen) begin
         @(posedge clk);
         @(posedge clk); #1;
         rst = 1'b1;
         @(negedge clk);
         @(negedge clk);
         check_all_zero("t6_reset");
         @(posedge clk); #1;
         rst = 1'b0;
         tick(30);
         check("t6_ret_cycles", c_ret_hi, 3);
         check("t6_no_vend", c_vnd_hi, 0);
      end

      // ---- table-driven single presses ----
      for (int i = 0; i < 8; i++) begin
         clear_mon();
         bus.insertCoin = vt[i].ins;
         tick(1);
         set_line(vt[i].line, 1'b1);
         tick(vt[i].hold);
         set_line(vt[i].line, 1'b0);
         tick(30);
         check($sformatf("vec%0d_fifty", i),  c_fifty,  vt[i].e_fifty);
         check($sformatf("vec%0d_dollar", i), c_dollar, vt[i].e_dollar);
         check($sformatf("vec%0d_cancel", i), c_cancel, vt[i].e_cancel);
         check($sformatf("vec%0d_reject", i), c_rej_hi, vt[i].e_rej);
      end

      // ---- randomized presses vs event-order model ----
      clear_mon();
      exp_q.delete();
      for (int n = 0; n < 25; n++) begin
         line = int'($urandom_range(0, 2));
         ins  = 1'($urandom_range(0, 1));
         hold = int'($urandom_range(8, 16));
         gap  = int'($urandom_range(12, 20));
         // Model: cancel always reported; a coin is reported when accepted,
         // otherwise it becomes one reject pulse.
         if (line == 2)  exp_q.push_back(2'd2);
         else if (ins)   exp_q.push_back(2'(line));
         else            exp_q.push_back(2'd3);
         bus.insertCoin = ins;
         tick(1);
         set_line(line, 1'b1);
         tick(hold);
         set_line(line, 1'b0);
         tick(gap);
      end
      tick(20);
      check("rand_count", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size())
            check($sformatf("rand_ev%0d", i), int'(got_q[i]), int'(exp_q[i]));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
